// File: rtl/calendar_date.sv
// Month/day/day-of-year calendar counter with a validated load path.
// A legal load spends one CALC cycle rebuilding day-of-year from the month table.
module calendar_date #(
    parameter int RESET_MONTH = 1,
    parameter int RESET_DAY   = 1,
    parameter int DOY_W       = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             leap,
    input  logic             load_valid,
    input  logic [3:0]       load_month,
    input  logic [4:0]       load_day,
    output logic             load_ready,
    output logic             load_err,
    output logic [3:0]       month,
    output logic [4:0]       day,
    output logic [DOY_W-1:0] doy,
    output logic [7:0]       month_bcd,
    output logic [7:0]       day_bcd,
    output logic             year_wrap
);

    typedef enum logic [0:0] {
        IDLE,
        CALC
    } state_t;

    state_t state;
    logic   pending;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = lp ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    // Days in all months before m; February's extra day only counts once past it.
    function automatic logic [8:0] cum_days(input logic [3:0] m, input logic lp);
        logic [8:0] base;
        case (m)
            4'd2:    base = 9'd31;
            4'd3:    base = 9'd59;
            4'd4:    base = 9'd90;
            4'd5:    base = 9'd120;
            4'd6:    base = 9'd151;
            4'd7:    base = 9'd181;
            4'd8:    base = 9'd212;
            4'd9:    base = 9'd243;
            4'd10:   base = 9'd273;
            4'd11:   base = 9'd304;
            4'd12:   base = 9'd334;
            default: base = 9'd0;
        endcase
        cum_days = (lp && (m > 4'd2)) ? base + 9'd1 : base;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        if (v >= 5'd30) begin
            to_bcd = {4'd3, 4'(v - 5'd30)};
        end else if (v >= 5'd20) begin
            to_bcd = {4'd2, 4'(v - 5'd20)};
        end else if (v >= 5'd10) begin
            to_bcd = {4'd1, 4'(v - 5'd10)};
        end else begin
            to_bcd = {4'd0, v[3:0]};
        end
    endfunction

    logic [4:0]       cur_len;
    logic             month_end;
    logic             wrap;
    logic [3:0]       next_month;
    logic [4:0]       next_day;
    logic [DOY_W-1:0] next_doy;
    logic             load_legal;
    logic [DOY_W-1:0] calc_doy;

    // An out-of-range day (e.g. Feb 29 after leap drops) is treated as month end.
    always_comb begin
        cur_len   = month_len(month, leap);
        month_end = (day >= cur_len);
        wrap      = month_end && (month == 4'd12);
        next_day  = month_end ? 5'd1 : day + 5'd1;
        if (!month_end) begin
            next_month = month;
        end else if (wrap) begin
            next_month = 4'd1;
        end else begin
            next_month = month + 4'd1;
        end
        if (wrap) begin
            next_doy = DOY_W'(1);
        end else if (doy < DOY_W'(366)) begin
            next_doy = doy + DOY_W'(1);
        end else begin
            next_doy = doy;
        end
        load_legal = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                     (load_day >= 5'd1) && (load_day <= month_len(load_month, leap));
        calc_doy   = DOY_W'(cum_days(month, leap)) + DOY_W'(day);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            load_err   <= 1'b0;
            year_wrap  <= 1'b0;
            month      <= 4'(RESET_MONTH);
            day        <= 5'(RESET_DAY);
            doy        <= DOY_W'(cum_days(4'(RESET_MONTH), 1'b0)) + DOY_W'(RESET_DAY);
            month_bcd  <= to_bcd(5'(RESET_MONTH));
            day_bcd    <= to_bcd(5'(RESET_DAY));
        end else begin
            load_err  <= 1'b0;
            year_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // A load always beats a tick; a legal one drops any pending tick too.
                        if (load_legal) begin
                            month      <= load_month;
                            day        <= load_day;
                            month_bcd  <= to_bcd({1'b0, load_month});
                            day_bcd    <= to_bcd(load_day);
                            pending    <= 1'b0;
                            state      <= CALC;
                            load_ready <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (tick || pending) begin
                        month     <= next_month;
                        day       <= next_day;
                        doy       <= next_doy;
                        month_bcd <= to_bcd({1'b0, next_month});
                        day_bcd   <= to_bcd(next_day);
                        year_wrap <= wrap;
                        pending   <= 1'b0;
                    end
                end
                CALC: begin
                    doy        <= calc_doy;
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    if (tick) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
